// File: rtl/fire_sched_pkg.sv
// Shared helpers for the firing scheduler: saturating add, popcount and the
// default signal count (an index equal to N encodes "no choice").
package fire_sched_pkg;

    localparam int unsigned DefaultN = 8;

    // Operands are widened to 64 bits; w is the destination width (<= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] max_v;
        logic [64:0] sum;
        logic [63:0] res;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum   = {1'b0, a} + {1'b0, b};
        res   = (sum > {1'b0, max_v}) ? max_v : sum[63:0];
        return res;
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            cnt += 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_find_first.sv
// Rotating-priority finder: first set bit of vec searching upward from start,
// wrapping at N.
module rr_find_first
    import fire_sched_pkg::*;
#(
    parameter int unsigned N    = DefaultN,
    parameter int unsigned IDXW = $clog2(N + 1)
) (
    input  logic [N-1:0]    vec,
    input  logic [IDXW-1:0] start,
    output logic [N-1:0]    onehot,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    int j;

    // Walk offsets high to low so the smallest offset from start wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        j      = 0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            j = int'(start) + off;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            if (vec[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = IDXW'(j);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fire_scheduler.sv
// Bounded-fair firing scheduler: turns the excited vector into per-signal fire
// enables, with starvation forcing, deadlock detection and firing statistics.
module fire_scheduler
    import fire_sched_pkg::*;
#(
    parameter int unsigned N             = DefaultN,
    parameter int unsigned MAX_WAIT      = 15,
    parameter bit          ALLOW_STUTTER = 1'b1,
    parameter int unsigned CNTW          = 32,
    parameter int unsigned IDXW          = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    excited,
    input  logic [IDXW-1:0] choice,
    input  logic            par,
    output logic [N-1:0]    fire,
    output logic            idle,
    output logic            deadlock,
    output logic [N-1:0]    starved,
    output logic [CNTW-1:0] fire_cnt,
    output logic [CNTW-1:0] step_cnt
);

    localparam int unsigned AW = $clog2(MAX_WAIT + 1);
    localparam logic [AW-1:0] AgeMax = AW'(MAX_WAIT);

    logic [AW-1:0]   age_q [N];
    logic [AW-1:0]   age_d [N];
    logic [IDXW-1:0] rr_q, rr_d;
    logic            deadlock_q;
    logic [CNTW-1:0] fire_cnt_q, fire_cnt_d;
    logic [CNTW-1:0] step_cnt_q, step_cnt_d;

    logic [N-1:0]    urgent, choice_oh, choice_hit;
    logic [N-1:0]    urg_oh, fb_oh;
    logic [IDXW-1:0] urg_idx, fb_idx, sel_idx;
    logic            urg_valid, fb_valid, sel_one;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            starved[i]   = (age_q[i] == AgeMax);
            choice_oh[i] = (choice == IDXW'(i));
        end
    end

    assign urgent     = excited & starved;
    assign choice_hit = choice_oh & excited;
    assign idle       = (excited == '0);

    rr_find_first #(.N(N), .IDXW(IDXW)) u_find_urgent (
        .vec    (urgent),
        .start  (rr_q),
        .onehot (urg_oh),
        .idx    (urg_idx),
        .valid  (urg_valid)
    );

    rr_find_first #(.N(N), .IDXW(IDXW)) u_find_fallback (
        .vec    (excited),
        .start  (rr_q),
        .onehot (fb_oh),
        .idx    (fb_idx),
        .valid  (fb_valid)
    );

    always_comb begin
        fire    = '0;
        sel_one = 1'b0;
        sel_idx = '0;
        if (!reset) begin
            fire = '0;
        end else if (par) begin
            fire = excited;
        end else if (urg_valid) begin
            fire    = urg_oh;
            sel_one = 1'b1;
            sel_idx = urg_idx;
        end else if (choice_hit != '0) begin
            fire    = choice_hit;
            sel_one = 1'b1;
            sel_idx = choice;
        end else if (!ALLOW_STUTTER && fb_valid) begin
            fire    = fb_oh;
            sel_one = 1'b1;
            sel_idx = fb_idx;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (sel_one) begin
            rr_d = (sel_idx == IDXW'(N - 1)) ? '0 : sel_idx + IDXW'(1);
        end
        for (int i = 0; i < int'(N); i++) begin
            if (fire[i] || !excited[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] == AgeMax) begin
                age_d[i] = age_q[i];
            end else begin
                age_d[i] = age_q[i] + AW'(1);
            end
        end
        fire_cnt_d = CNTW'(sat_add(64'(fire_cnt_q), 64'(popcount(64'(fire))), CNTW));
        step_cnt_d = CNTW'(sat_add(64'(step_cnt_q), 64'(fire != '0), CNTW));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N); i++) begin
                age_q[i] <= '0;
            end
            rr_q       <= '0;
            deadlock_q <= 1'b0;
            fire_cnt_q <= '0;
            step_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                age_q[i] <= age_d[i];
            end
            rr_q       <= rr_d;
            deadlock_q <= deadlock_q | idle;
            fire_cnt_q <= fire_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign deadlock = deadlock_q;
    assign fire_cnt = fire_cnt_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: doc/fire_scheduler.md
# fire_scheduler

Parametrised firing scheduler for formal and performance models of asynchronous circuits. Each cycle it takes the vector of excited signals and produces the per-signal enable vector that drives the signal state flops. It replaces the free, unbounded firing-index register with a bounded-fair, optionally step-parallel scheduler. It also provides deadlock detection and firing statistics.

## Interface

Parameters:
- `N`, default 8: number of schedulable signals (≥2).
- `MAX_WAIT`, default 15: cycles an excited signal may stay unfired before it is forced to fire (≥1).
- `ALLOW_STUTTER`, default 1: 1 = cycles with no firing are permitted while signals are excited; 0 = something always fires when anything is excited.
- `CNTW`, default 32: width of the statistics counters.
- `IDXW`, derived as `$clog2(N+1)`: index width. Value `N` means "no choice".

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `excited`, in, N: bit i = 1 when signal i's precap value differs from its current value.
- `choice`, in, IDXW: index the environment or formal tool proposes to fire. Left unconstrained in formal runs.
- `par`, in, 1: 1 = fire every excited signal this cycle (synchronous-step mode).
- `fire`, out, N: enable vector. Combinational, always a subset of `excited`.
- `idle`, out, 1: combinational; high when `excited == 0`.
- `deadlock`, out, 1: sticky; set at the first edge where `idle` is high. Cleared only by reset.
- `starved`, out, N: registered; bit i = 1 when `age[i] == MAX_WAIT`.
- `fire_cnt`, out, CNTW: total number of signal firings, saturating.
- `step_cnt`, out, CNTW: number of cycles with `fire != 0`, saturating.

## Operation

State:
- `age[i]`: per-signal wait counter, `$clog2(MAX_WAIT+1)` bits.
- `rr`: rotating pointer, IDXW bits, range 0..N-1.
- `deadlock`, `fire_cnt`, `step_cnt`.

All state resets to 0. While `reset` is low, `fire` is 0.

`fire` selection, in priority order:
1. `par` = 1: `fire = excited`.
2. Urgent set `U = excited & starved` is non-empty: one-hot at the first set bit of U, searching from `rr` upward with wrap.
3. `choice < N` and `excited[choice]`: one-hot at `choice`.
4. `ALLOW_STUTTER` = 0 and `excited != 0`: one-hot at the first excited bit, searching from `rr` with wrap.
5. Otherwise: `fire = 0` (stutter).

Register updates at each edge:
- `age[i]`:
  - cleared to 0 if `fire[i]` or `!excited[i]`;
  - else incremented, saturating at `MAX_WAIT`.
- `rr`: when a one-hot fire at index k occurs, `rr <= (k+1) mod N`. Unchanged on stutter or `par` firings.
- `fire_cnt += popcount(fire)`, saturating at all-ones.
- `step_cnt += (fire != 0)`, saturating at all-ones.
- `deadlock <= deadlock | idle`.

Boundary cases:
- `choice >= N`, or `choice` pointing at a non-excited signal: treated as no choice. Never produces a firing of a non-excited signal.
- `MAX_WAIT` reached by several signals at once: one fires per cycle in rotating order. The others stay saturated and are served on following cycles.
- A signal de-excites (input withdrawn) while waiting: its age clears. This is not an error.
- Reset asserted mid-operation: immediate asynchronous clear of all state, with `fire` forced to 0 in the same cycle.
- Counter saturation: holds at all-ones and does not wrap.

## Timing

- `fire` and `idle` are zero-latency combinational functions of `excited`, `choice`, `par` and registered state. The consumer flops use `fire` as their enable in the same cycle.
- `starved` and the statistics counters reflect firings up to and including the previous edge.
- Fairness bound: a continuously excited signal fires within `MAX_WAIT + N` cycles.
- No combinational path from `fire` back into `excited` inside this block.

## Structure

- Package `fire_sched_pkg` holds:
  - the saturating-add helper function;
  - the `popcount` function;
  - the localparam for the no-choice encoding (`N`).
- Sub-module `rr_find_first` (params `N`, `IDXW`): rotating-priority first-set-bit finder. Inputs are a vector and a start pointer; outputs are a one-hot vector, an index and a valid flag. It is instantiated twice: once for the urgent set and once for the non-stutter fallback.

## Test plan

- **Reset:** `reset` = 0 with `excited` = 8'hFF → `fire` = 0, all counters 0, `deadlock` = 0. Deassert with `excited` = 0 → `deadlock` = 1 after one edge.
- **Choice path:** `excited` = 8'b0000_1010, `choice` = 3 → `fire` = 8'b0000_1000; `choice` = 2 → `fire` = 0 (stutter); `choice` = 8 → `fire` = 0.
- **Starvation:** `excited[5]` held, `choice` = 8 for 15 cycles → `starved[5]` = 1 on cycle 15 and `fire[5]` = 1 in that cycle; `age[5]` = 0 afterwards.
- **Simultaneous urgency:** bits 1 and 6 both saturate with `rr` = 4 → bit 6 fires first, then bit 1 on the next cycle; `rr` ends at 2.
- **Parallel and non-stutter modes:**
  - `par` = 1, `excited` = 8'hA5 → `fire` = 8'hA5; `fire_cnt` increases by 4 and `step_cnt` by 1.
  - `ALLOW_STUTTER` = 0, `choice` = 8, `excited` = 8'h30, `rr` = 0 → `fire` = 8'h10.
- **Saturation:** with `CNTW` = 4, after 20 firing cycles `fire_cnt` = 4'hF and `step_cnt` = 4'hF. An asynchronous reset mid-burst clears both immediately.
